// File: rtl/display_bcd_converter_if.sv
// Request/result bundle between the output port and the BCD converter.
// The master drives load requests; the slave returns the displayed digits.
interface display_bcd_converter_if;
   logic        wr;
   logic [31:0] data;
   logic        busy;
   logic        done;
   logic        ovf;
   logic [31:0] bcd;
   logic [7:0]  lzmask;

   modport master (
      output wr,
      output data,
      input  busy,
      input  done,
      input  ovf,
      input  bcd,
      input  lzmask
   );

   modport slave (
      input  wr,
      input  data,
      output busy,
      output done,
      output ovf,
      output bcd,
      output lzmask
   );
endinterface

// File: rtl/display_bcd_converter.sv
// Sequential shift-and-add-3 binary to 8-digit BCD converter for HEX displays.
// Results are published only on the DONE transition, so displays never flicker.
module display_bcd_converter (
   input  logic                    clock,
   input  logic                    resetn,
   display_bcd_converter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam logic [31:0] MAX_VAL  = 32'd99_999_999;
   localparam logic [4:0]  N_ITER   = 5'd27;
   localparam logic [31:0] OVF_BCD  = 32'hEEEE_EEEE;
   localparam logic [7:0]  LZ_RESET = 8'hFE;

   state_t      state_q, state_d;
   logic [26:0] bin_q, bin_d;
   logic [31:0] scr_q, scr_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        ovp_q, ovp_d;
   logic [31:0] bcd_q, bcd_d;
   logic [7:0]  lz_q, lz_d;
   logic        ovf_q, ovf_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;

   logic [31:0] adj;
   logic [7:0]  lz_calc;

   // Per-digit +3 correction ahead of the shift; no carry between digits.
   always_comb begin
      adj = scr_q;
      for (int i = 0; i < 8; i++) begin
         if (scr_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      logic zero_run;
      lz_calc  = 8'h00;
      zero_run = 1'b1;
      for (int i = 7; i >= 1; i--) begin
         zero_run   = zero_run && (scr_q[4*i +: 4] == 4'd0);
         lz_calc[i] = zero_run;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      ovp_d   = ovp_q;
      bcd_d   = bcd_q;
      lz_d    = lz_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.wr) begin
               if (bus.data > MAX_VAL) begin
                  ovp_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  ovp_d   = 1'b0;
                  bin_d   = bus.data[26:0];
                  scr_d   = 32'h0;
                  cnt_d   = N_ITER;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            scr_d = {adj[30:0], bin_q[26]};
            bin_d = {bin_q[25:0], 1'b0};
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (ovp_q) begin
               bcd_d = OVF_BCD;
               lz_d  = 8'h00;
               ovf_d = 1'b1;
            end else begin
               bcd_d = scr_q;
               lz_d  = lz_calc;
               ovf_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         bin_q   <= 27'h0;
         scr_q   <= 32'h0;
         cnt_q   <= 5'd0;
         ovp_q   <= 1'b0;
         bcd_q   <= 32'h0;
         lz_q    <= LZ_RESET;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         ovp_q   <= ovp_d;
         bcd_q   <= bcd_d;
         lz_q    <= lz_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.ovf    = ovf_q;
   assign bus.bcd    = bcd_q;
   assign bus.lzmask = lz_q;

   a_busy_done_excl: assert property (
      @(posedge clock) disable iff (!resetn) !(busy_q && done_q)
   );

endmodule

// File: doc/display_bcd_converter.md
# display_bcd_converter

Converts a 32-bit binary value into eight packed BCD digits for the eight HEX displays on the DE2 board. It sits between the pipelined computer's memory-mapped output port and the eight per-digit seven-segment decoders: each nibble of `bcd` drives one decoder's 4-bit `data` input. Conversion is sequential (shift-and-add-3, one bit per clock), and the displayed value stays stable until a new result is complete.

## Interface
Parameters: none (widths fixed: 8 digits, 27-bit conversion core).
- clock  in  1  system clock, rising-edge active
- resetn  in  1  asynchronous, active-low reset
- wr  in  1  load request; sampled only in IDLE
- data  in  32  unsigned binary value to display
- busy  out  1  high while a conversion is in progress (state != IDLE)
- done  out  1  one-cycle pulse when `bcd`/`lzmask`/`ovf` have just been updated
- ovf  out  1  last accepted value exceeded 99_999_999
- bcd  out  32  digit i at [4i+3:4i]; digit 0 is the least significant
- lzmask  out  8  bit i=1: digit i is a leading zero (suppression hint); bit 0 always 0

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE + wr=1:
  - data > 99_999_999: go to DONE with overflow flagged.
  - otherwise: load data[26:0] into the binary shift register, clear the 32-bit BCD scratch, set iteration counter to 27, go to SHIFT.
- IDLE + wr=0: hold.
- SHIFT, one iteration per clock:
  - every scratch digit ≥5 gets +3 (4-bit add, no carry between digits);
  - then {scratch, binary} shifts left 1;
  - counter decrements; after the 27th iteration go to DONE.
- DONE, single cycle:
  - normal: bcd ← scratch, ovf ← 0, lzmask recomputed.
  - overflow: bcd ← 32'hEEEE_EEEE, lzmask ← 8'h00, ovf ← 1.
  - done ← 1; go to IDLE.
- lzmask: for i = 1..7, bit i = 1 iff digits 7..i are all zero. Bit 0 is always 0.
- wr while busy=1 (SHIFT or DONE) is ignored; there is no queuing.
- `bcd`, `lzmask` and `ovf` change only in the DONE transition, so the displays never show partial results.

## Timing
- Reset (asynchronous, resetn=0): state=IDLE, busy=0, done=0, ovf=0, bcd=32'h0000_0000, lzmask=8'hFE.
- Reset mid-conversion aborts the conversion; all outputs take their reset values immediately.
- Normal conversion, with wr sampled at edge E0:
  - busy=1 after E0;
  - iterations run on E1..E27;
  - outputs update and done=1 after E28;
  - busy=0 after E28;
  - done=0 after E29.
- Overflow: wr at E0 → outputs update, done=1 and busy=0 after E1.
- done and busy are never high in the same cycle.
- A new wr may be presented in the cycle done=1; it is accepted at the next edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then wr with data=0 → done 28 cycles after wr edge; bcd=32'h0000_0000, lzmask=8'hFE, ovf=0.
- data=12_345_678 (0x00BC614E) → bcd=32'h1234_5678, lzmask=8'h00, ovf=0; bcd holds its prior value and busy=1 for all 28 cycles until done.
- data=1_000 → bcd=32'h0000_1000, lzmask=8'hF0; then data=99_999_999 → bcd=32'h9999_9999, lzmask=8'h00.
- data=100_000_000 → done after 2 edges, bcd=32'hEEEE_EEEE, lzmask=8'h00, ovf=1; next wr with data=7 → ovf=0, bcd=32'h0000_0007, lzmask=8'hFE.
- wr(data=5) followed by wr(data=9) at cycle 10 of the busy period → second request ignored, result bcd=32'h0000_0005, exactly one done pulse; wr(data=9) in the done cycle → accepted, bcd=32'h0000_0009.
- Start conversion of 12_345_678, assert resetn=0 at cycle 15 → outputs immediately at reset values, no done pulse; after release, a new conversion completes correctly.
